// File: rtl/sc_matmul_engine_if.sv
// sc_matmul_engine_if: job control, operand-fetch and result-write signals of the SC matmul engine
interface sc_matmul_engine_if #(
    parameter int INPUT_FEATURES = 4,
    parameter int OUTPUT_FEATURES = 4,
    parameter int MAX_BATCH = 16,
    parameter int BINARY_PRECISION = 8
);
    localparam int RW = $clog2(MAX_BATCH + 1);
    localparam int IAW = $clog2(MAX_BATCH);
    localparam int WAW = $clog2(OUTPUT_FEATURES);
    localparam int OAW = $clog2(MAX_BATCH * OUTPUT_FEATURES);
    localparam int DW = BINARY_PRECISION * INPUT_FEATURES;
    logic start;
    logic [RW-1:0] num_rows;
    logic busy;
    logic done;
    logic [IAW-1:0] in_addr;
    logic [DW-1:0] in_data;
    logic [WAW-1:0] wt_addr;
    logic [DW-1:0] wt_data;
    logic out_wr_en;
    logic [OAW-1:0] out_addr;
    logic [BINARY_PRECISION-1:0] out_data;
    modport master (
        output start, num_rows, in_data, wt_data,
        input busy, done, in_addr, wt_addr, out_wr_en, out_addr, out_data
    );
    modport slave (
        input start, num_rows, in_data, wt_data,
        output busy, done, in_addr, wt_addr, out_wr_en, out_addr, out_data
    );
endinterface

// File: rtl/sc_matmul_engine.sv
// sc_matmul_engine: stochastic-computing matrix multiply with its own fetch/run/write sequencer
module sc_matmul_engine #(
    parameter int INPUT_FEATURES = 4,
    parameter int OUTPUT_FEATURES = 4,
    parameter int MAX_BATCH = 16,
    parameter int BINARY_PRECISION = 8,
    parameter int STOCHASTIC_CYCLES = 1,
    parameter logic [BINARY_PRECISION-1:0] SEED0 = 8'h01,
    parameter logic [BINARY_PRECISION-1:0] SEED1 = 8'hA5,
    parameter logic [BINARY_PRECISION-1:0] TAPS0 = 8'hB8,
    parameter logic [BINARY_PRECISION-1:0] TAPS1 = 8'h8E
) (
    input logic clk,
    input logic rst,
    sc_matmul_engine_if.slave bus
);
    localparam int N = INPUT_FEATURES;
    localparam int O = OUTPUT_FEATURES;
    localparam int P = BINARY_PRECISION;
    localparam int LS = $clog2(STOCHASTIC_CYCLES);
    localparam int TW = P + LS;
    localparam int CW = P + LS + 1;
    localparam int SW = $clog2(N);
    localparam int RW = $clog2(MAX_BATCH + 1);
    localparam int IAW = $clog2(MAX_BATCH);
    localparam int WAW = $clog2(O);
    localparam int OAW = $clog2(MAX_BATCH * O);

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, RUN, WRITE, DONE} state_t;

    state_t state_q;
    logic [IAW-1:0] m_q;
    logic [WAW-1:0] o_q;
    logic [RW-1:0] rows_q;
    logic [N-1:0][P-1:0] x_q, w_q;
    logic [P-1:0] rng0_q, rng1_q, rng0_d, rng1_d;
    logic [SW-1:0] sel_q;
    logic [TW-1:0] cyc_q;
    logic [CW-1:0] cnt_q, cnt_d, scaled;
    logic [N-1:0] prod;
    logic [P-1:0] res_d;
    logic busy_q, done_q, wr_q;
    logic [OAW-1:0] oaddr_q;
    logic [P-1:0] odata_q;

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.in_addr = m_q;
    assign bus.wt_addr = o_q;
    assign bus.out_wr_en = wr_q;
    assign bus.out_addr = oaddr_q;
    assign bus.out_data = odata_q;

    // Galois LFSR steps, per-lane SNG/AND products, MUX-selected count and saturated scaled result
    always_comb begin
        rng0_d = (rng0_q >> 1) ^ (rng0_q[0] ? TAPS0 : '0);
        rng1_d = (rng1_q >> 1) ^ (rng1_q[0] ? TAPS1 : '0);
        prod = '0;
        for (int n = 0; n < N; n++) prod[n] = (x_q[n] >= rng0_q) & (w_q[n] >= rng1_q);
        cnt_d = cnt_q + CW'(prod[sel_q]);
        scaled = cnt_d >> LS;
        res_d = |scaled[CW-1:P] ? '1 : scaled[P-1:0];
    end

    // Job sequencer: index walk, operand load, W-cycle window, registered result write
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q <= '0;
            o_q <= '0;
            rows_q <= '0;
            x_q <= '0;
            w_q <= '0;
            rng0_q <= SEED0;
            rng1_q <= SEED1;
            sel_q <= '0;
            cyc_q <= '0;
            cnt_q <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            wr_q <= 1'b0;
            oaddr_q <= '0;
            odata_q <= '0;
        end else begin
            done_q <= 1'b0;
            wr_q <= 1'b0;
            case (state_q)
                IDLE: if (bus.start) begin
                    m_q <= '0;
                    o_q <= '0;
                    rows_q <= bus.num_rows;
                    state_q <= bus.num_rows == '0 ? DONE : FETCH;
                    busy_q <= bus.num_rows != '0;
                    done_q <= bus.num_rows == '0;
                end
                FETCH: state_q <= LOAD;
                LOAD: begin
                    x_q <= bus.in_data;
                    w_q <= bus.wt_data;
                    rng0_q <= SEED0;
                    rng1_q <= SEED1;
                    sel_q <= '0;
                    cyc_q <= '0;
                    cnt_q <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    rng0_q <= rng0_d;
                    rng1_q <= rng1_d;
                    sel_q <= sel_q + SW'(1);
                    cyc_q <= cyc_q + TW'(1);
                    cnt_q <= cnt_d;
                    if (&cyc_q) begin
                        state_q <= WRITE;
                        wr_q <= 1'b1;
                        oaddr_q <= OAW'(m_q) * OAW'(O) + OAW'(o_q);
                        odata_q <= res_d;
                    end
                end
                WRITE: if (o_q != WAW'(O - 1)) begin
                    o_q <= o_q + WAW'(1);
                    state_q <= FETCH;
                end else begin
                    o_q <= '0;
                    if (RW'(m_q) + RW'(1) != rows_q) begin
                        m_q <= m_q + IAW'(1);
                        state_q <= FETCH;
                    end else begin
                        state_q <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
                DONE: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sc_matmul_engine.sv
// tb_sc_matmul_engine: directed jobs with a write scoreboard for the SC matmul engine (S=1 and S=4)
module tb_sc_matmul_engine;
    localparam int N = 4;
    localparam int O = 4;
    localparam int MB = 16;
    localparam int P = 8;
    localparam int RW = $clog2(MB + 1);

    typedef struct {int addr; int data; int m; int o;} exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] xmem [MB][N];
    logic [7:0] wmem [O][N];
    exp_t q1[$];
    exp_t q4[$];
    int checks = 0;
    int failures = 0;
    int writes1 = 0;
    int dones1 = 0;

    always #5 clk = ~clk;

    sc_matmul_engine_if #(.INPUT_FEATURES(N), .OUTPUT_FEATURES(O), .MAX_BATCH(MB), .BINARY_PRECISION(P)) bus();
    sc_matmul_engine_if #(.INPUT_FEATURES(N), .OUTPUT_FEATURES(O), .MAX_BATCH(MB), .BINARY_PRECISION(P)) bus4();

    sc_matmul_engine #(.STOCHASTIC_CYCLES(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
    sc_matmul_engine #(.STOCHASTIC_CYCLES(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    // synchronous-read input and weight memories, one read port per engine
    always @(posedge clk) for (int n = 0; n < N; n++) begin
        bus.in_data[n*P +: P] <= xmem[bus.in_addr][n];
        bus.wt_data[n*P +: P] <= wmem[bus.wt_addr][n];
    end
    always @(posedge clk) for (int k = 0; k < N; k++) begin
        bus4.in_data[k*P +: P] <= xmem[bus4.in_addr][k];
        bus4.wt_data[k*P +: P] <= wmem[bus4.wt_addr][k];
    end

    // reference: seeded Galois LFSRs, unsigned SNG compare, round-robin lane select, scale and saturate
    function automatic int ref_out(input int m, input int o, input int s);
        logic [7:0] r0 = 8'h01;
        logic [7:0] r1 = 8'hA5;
        int cnt = 0;
        for (int c = 0; c < s * 256; c++) begin
            if (xmem[m][c % N] >= r0 && wmem[o][c % N] >= r1) cnt++;
            r0 = r0[0] ? ((r0 >> 1) ^ 8'hB8) : (r0 >> 1);
            r1 = r1[0] ? ((r1 >> 1) ^ 8'h8E) : (r1 >> 1);
        end
        cnt = cnt / s;
        return cnt > 255 ? 255 : cnt;
    endfunction

    task automatic check_wr(input exp_t e, input int a, input int d, input int ia, input int wa, input string t);
        checks++;
        assert (a === e.addr) else begin failures++; $error("FAIL %s out_addr observed=%0d expected=%0d", t, a, e.addr); end
        checks++;
        assert (d === e.data) else begin failures++; $error("FAIL %s out_data@%0d observed=%0d expected=%0d", t, e.addr, d, e.data); end
        checks++;
        assert (ia === e.m && wa === e.o) else begin failures++; $error("FAIL %s row_addr observed=(%0d,%0d) expected=(%0d,%0d)", t, ia, wa, e.m, e.o); end
    endtask

    always @(negedge clk) if (!rst && bus.done) dones1++;

    always @(negedge clk) if (!rst && bus.out_wr_en) begin
        writes1++;
        checks++;
        assert (q1.size() != 0) else begin failures++; $error("FAIL wr_unexpected observed addr=%0d expected none", bus.out_addr); end
        if (q1.size() != 0) check_wr(q1.pop_front(), int'(bus.out_addr), int'(bus.out_data), int'(bus.in_addr), int'(bus.wt_addr), "s1");
    end

    always @(negedge clk) if (!rst && bus4.out_wr_en) begin
        checks++;
        assert (q4.size() != 0) else begin failures++; $error("FAIL wr4_unexpected observed addr=%0d expected none", bus4.out_addr); end
        if (q4.size() != 0) check_wr(q4.pop_front(), int'(bus4.out_addr), int'(bus4.out_data), int'(bus4.in_addr), int'(bus4.wt_addr), "s4");
    end

    task automatic fill(input int xlo, input int xhi, input int wlo, input int whi, input bit lane0_only);
        for (int m = 0; m < MB; m++) for (int n = 0; n < N; n++)
            xmem[m][n] = (lane0_only && n != 0) ? 8'h00 : 8'($urandom_range(xlo, xhi));
        for (int o = 0; o < O; o++) for (int n = 0; n < N; n++) wmem[o][n] = 8'($urandom_range(wlo, whi));
    endtask

    task automatic run_job(input int rows, input int fixed, input bit poke);
        int cyc = 0;
        bit busy_ok = 1'b1;
        int lim = rows * O * 259 + 20;
        for (int m = 0; m < rows; m++) for (int o = 0; o < O; o++)
            q1.push_back('{m * O + o, fixed < 0 ? ref_out(m, o, 1) : fixed, m, o});
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_rows = RW'(rows);
        @(posedge clk);
        #1 bus.start = 1'b0;
        while (cyc < lim) begin
            @(negedge clk);
            cyc++;
            if (bus.done) break;
            if (bus.busy !== (rows > 0)) busy_ok = 1'b0;
            if (poke) begin
                bus.start = (cyc == 10 || cyc == 300);
                bus.num_rows = RW'(5);
            end
        end
        bus.start = 1'b0;
        checks++;
        assert (bus.done === 1'b1 && cyc === rows * O * 259 + 1) else begin failures++; $error("FAIL job_len rows=%0d observed=%0d expected=%0d", rows, cyc, rows * O * 259 + 1); end
        checks++;
        assert (busy_ok && bus.busy === 1'b0) else begin failures++; $error("FAIL busy_window rows=%0d observed_ok=%0d expected=1", rows, busy_ok); end
        @(negedge clk);
        checks++;
        assert (bus.done === 1'b0) else begin failures++; $error("FAIL done_pulse observed=%0b expected=0", bus.done); end
        checks++;
        assert (q1.size() === 0) else begin failures++; $error("FAIL pending_writes observed=%0d expected=0", q1.size()); end
    endtask

    initial begin
        int cyc;
        int d0;
        bus.start = 1'b0;
        bus.num_rows = '0;
        bus4.start = 1'b0;
        bus4.num_rows = '0;
        fill(255, 255, 255, 255, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        assert ({bus.busy, bus.done, bus.out_wr_en, bus.out_addr, bus.out_data, bus.in_addr, bus.wt_addr} === '0) else begin failures++; $error("FAIL reset_s1 observed=%h expected=0", {bus.busy, bus.done, bus.out_wr_en, bus.out_addr, bus.out_data, bus.in_addr, bus.wt_addr}); end
        checks++;
        assert ({bus4.busy, bus4.done, bus4.out_wr_en, bus4.out_addr, bus4.out_data} === '0) else begin failures++; $error("FAIL reset_s4 observed=%h expected=0", {bus4.busy, bus4.done, bus4.out_wr_en, bus4.out_addr, bus4.out_data}); end
        rst = 1'b0;

        // reset in the middle of element 2's window
        for (int o = 0; o < O; o++) q1.push_back('{o, 255, 0, o});
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_rows = RW'(1);
        @(posedge clk);
        #1 bus.start = 1'b0;
        cyc = 0;
        while (writes1 < 2 && cyc < 2000) begin @(negedge clk); cyc++; end
        repeat (100) @(negedge clk);
        d0 = dones1;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        assert ({bus.busy, bus.done, bus.out_wr_en, bus.out_addr, bus.out_data, bus.in_addr, bus.wt_addr} === '0) else begin failures++; $error("FAIL midjob_reset observed=%h expected=0", {bus.busy, bus.done, bus.out_wr_en, bus.out_addr, bus.out_data, bus.in_addr, bus.wt_addr}); end
        rst = 1'b0;
        q1.delete();
        repeat (300) @(negedge clk);
        checks++;
        assert (writes1 === 2 && dones1 === d0 && bus.busy === 1'b0) else begin failures++; $error("FAIL post_reset_quiet observed writes=%0d dones=%0d expected writes=2 dones=%0d", writes1, dones1, d0); end

        fill(0, 0, 255, 255, 1'b0);
        run_job(1, 0, 1'b0);
        fill(255, 255, 255, 255, 1'b0);
        run_job(1, 255, 1'b0);
        fill(255, 255, 255, 255, 1'b1);
        run_job(1, 64, 1'b0);
        fill(0, 255, 0, 255, 1'b0);
        run_job(3, -1, 1'b1);
        d0 = writes1;
        run_job(0, 0, 1'b0);
        checks++;
        assert (writes1 === d0) else begin failures++; $error("FAIL zero_rows_writes observed=%0d expected=%0d", writes1, d0); end
        run_job(2, -1, 1'b0);

        // same select-weighting job on the S=4 engine
        fill(255, 255, 255, 255, 1'b1);
        for (int o = 0; o < O; o++) q4.push_back('{o, 64, 0, o});
        @(negedge clk);
        bus4.start = 1'b1;
        bus4.num_rows = RW'(1);
        @(posedge clk);
        #1 bus4.start = 1'b0;
        cyc = 0;
        while (cyc < O * 1027 + 20) begin
            @(negedge clk);
            cyc++;
            if (bus4.done) break;
        end
        checks++;
        assert (bus4.done === 1'b1 && cyc === O * 1027 + 1) else begin failures++; $error("FAIL s4_job_len observed=%0d expected=%0d", cyc, O * 1027 + 1); end
        checks++;
        assert (q4.size() === 0) else begin failures++; $error("FAIL s4_pending observed=%0d expected=0", q4.size()); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sc_matmul_engine.md
Name: sc_matmul_engine

Overview:
- Parametrised, self-sequencing stochastic-computing matrix multiply: OUT[m][o] = (1/N)·Σn X[m][n]·W[o][n], unipolar, P-bit fixed-point.
- Fetches input rows and weight rows from external synchronous-read memories through its own FSM.
- Per output element: runs one SNG/AND/MUX-add/count window, then writes one P-bit result.
- Sits between the input/weight buffers and the output buffer of the SC accelerator datapath.

Parameters:
- INPUT_FEATURES, 4: N, vector length and number of SNG pairs (power of 2, ≥2).
- OUTPUT_FEATURES, 4: O, weight rows per input row.
- MAX_BATCH, 16: M_max, largest number of rows per job.
- BINARY_PRECISION, 8: P, operand/result width (4..16).
- STOCHASTIC_CYCLES, 1: S, window multiplier (power of 2); window W = S·2^P cycles.
- SEED0 / SEED1, 8'h01 / 8'hA5: nonzero LFSR seeds, never all-ones.
- TAPS0 / TAPS1, 8'hB8 / 8'h8E: Galois feedback masks, maximal-length for P.

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, synchronous, active-high.
- start, in, 1: job launch pulse; honoured only in IDLE.
- num_rows, in, clog2(MAX_BATCH+1): rows M for this job; sampled at start.
- busy, out, 1: high from the cycle after an accepted start until the done pulse.
- done, out, 1: one-cycle pulse at job end.
- in_addr, out, clog2(MAX_BATCH): input row address.
- in_data, in, P·N: input row; lane n at [n·P +: P]; valid 1 cycle after in_addr.
- wt_addr, out, clog2(O): weight row address.
- wt_data, in, P·N: weight row; same lane layout and latency as in_data.
- out_wr_en, out, 1: write strobe, 1 cycle per result.
- out_addr, out, clog2(MAX_BATCH·O): result address = m·O + o.
- out_data, out, P: result value.

Behaviour:
- Reset: all outputs are 0, FSM goes to IDLE, m = o = 0, and the LFSRs load their seeds. A reset mid-job aborts immediately: no further write and no done pulse.
- FSM states: IDLE → FETCH → LOAD → RUN → WRITE → (FETCH | DONE) → IDLE.
- IDLE:
  - start=1 with num_rows>0 → FETCH, m = o = 0.
  - start=1 with num_rows=0 → DONE directly; no memory access or write.
  - start is ignored in all other states.
- FETCH (1 cycle): drive in_addr=m, wt_addr=o.
- LOAD (1 cycle):
  - Register in_data and wt_data into operand registers.
  - Reload both LFSRs with their seeds; clear the select counter and the ones-counter.
  - Every window is therefore bit-reproducible.
- RUN (exactly W cycles, counter 0..W-1). Each cycle:
  - LFSR0/LFSR1 advance (Galois, values cycle through 1..2^P-1).
  - SNG bits: xb[n] = (X[n] ≥ rng0), wb[n] = (W[n] ≥ rng1), unsigned compare; the value uses the LFSR output before the advance.
  - Product p[n] = xb[n] & wb[n].
  - sel counter steps 0,1,..,N-1 then wraps; it starts at 0 in the first RUN cycle. r = p[sel].
  - ones-counter (width P+log2(S)+1) increments when r=1.
- WRITE (1 cycle):
  - out_wr_en=1, out_addr = m·O+o.
  - out_data = min(count >> log2(S), 2^P-1); saturation covers count = W.
- Index advance after WRITE:
  - o<O-1: o++ → FETCH.
  - else o=0; m<num_rows-1: m++ → FETCH.
  - else → DONE.
- DONE (1 cycle): done=1, busy=0 in this cycle → IDLE.
- Latency per element: W+3 cycles. Job length: M·O·(W+3)+1 cycles from the start accept.
- out_addr, out_data and out_wr_en are registered; they hold their last values (wr_en=0) outside WRITE.

Test Plan:
- Reset values: N=4, P=8, S=1; assert rst mid-RUN of job element 2 → next cycle all outputs 0, no out_wr_en, no done; a new start then runs cleanly from m=o=0.
- Zero operands: num_rows=1, all X=0, W=8'hFF → 4 writes, addr 0..3, out_data=0 each; done 1 cycle after the 4th write; exactly 4·259+1 cycles after the start accept.
- Full scale: all X=W=8'hFF → count 256 → saturated out_data=8'hFF for every element.
- Select weighting: X lane0=8'hFF, others 0, W all 8'hFF → lane 0 is selected 64/256 cycles → out_data=64. Repeat with S=4 → count 256 → out_data=64.
- Addressing: num_rows=3, O=4 → 12 writes with out_addr 0..11 in order; in_addr/wt_addr sequence (0,0),(0,1)..(2,3); start pulses asserted while busy are ignored.
- num_rows=0 → no in_addr/wt_addr activity, no writes, done pulse 1 cycle after start; busy never rises.
